// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths and the secondary writeback FIFO entry type.
package rf_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NUM_REGS = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rf_entry_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: core/secondary/scoreboard/register-file signals of the writeback arbiter.
interface rf_wb_arbiter_if #(
  parameter int AW = rf_pkg::AW,
  parameter int DW = rf_pkg::DW,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic          pri_valid;
  logic [AW-1:0] pri_addr;
  logic [DW-1:0] pri_data;
  logic          pri_stall;
  logic          sec_valid;
  logic          sec_ready;
  logic [AW-1:0] sec_addr;
  logic [DW-1:0] sec_data;
  logic          sb_set;
  logic [AW-1:0] sb_addr;
  logic [AW-1:0] q_addr1;
  logic [AW-1:0] q_addr2;
  logic          q_busy1;
  logic          q_busy2;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [CW-1:0] fifo_count;
  modport master (
    output pri_valid, pri_addr, pri_data, sec_valid, sec_addr, sec_data,
           sb_set, sb_addr, q_addr1, q_addr2,
    input  pri_stall, sec_ready, q_busy1, q_busy2, rf_we, rf_addr, rf_data, fifo_count
  );
  modport slave (
    input  pri_valid, pri_addr, pri_data, sec_valid, sec_addr, sec_data,
           sb_set, sb_addr, q_addr1, q_addr2,
    output pri_stall, sec_ready, q_busy1, q_busy2, rf_we, rf_addr, rf_data, fifo_count
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO with async reset; pointers wrap naturally since DEPTH is a power of 2.
module rf_wb_fifo #(
  parameter int DEPTH = 4,
  parameter type T = rf_pkg::rf_entry_t,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between core writeback and buffered
// long-latency results, with anti-starvation aging and a pending-register scoreboard.
module rf_wb_arbiter
  import rf_pkg::rf_entry_t, rf_pkg::NUM_REGS, rf_pkg::REG_ZERO;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int AW = rf_pkg::AW,
  parameter int DW = rf_pkg::DW
) (
  input logic clk,
  input logic reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt;
  logic [NUM_REGS-1:0] pending;
  rf_entry_t head, sec_entry;
  logic full, empty, push, pop, pri_grant, head_commit, force_head;
  logic [AW-1:0] wr_addr;
  assign sec_entry = '{addr: bus.sec_addr, data: bus.sec_data};
  assign bus.sec_ready = !reset && !full;
  assign push = bus.sec_valid && bus.sec_ready;
  rf_wb_fifo #(.DEPTH(DEPTH), .T(rf_entry_t)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(sec_entry),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(bus.fifo_count)
  );
  // A primary write to the head's register kills the older buffered value.
  always_comb begin
    force_head = !empty && bus.pri_valid && starve_cnt == SLIM;
    pri_grant = bus.pri_valid && !force_head;
    head_commit = !empty && (!bus.pri_valid || force_head);
    pop = head_commit || (pri_grant && !empty && bus.pri_addr == head.addr);
    wr_addr = head_commit ? head.addr : bus.pri_addr;
    bus.rf_addr = wr_addr;
    bus.rf_data = head_commit ? head.data : bus.pri_data;
    bus.rf_we = (pri_grant || head_commit) && wr_addr != REG_ZERO;
    bus.pri_stall = force_head;
  end
  assign bus.q_busy1 = pending[bus.q_addr1];
  assign bus.q_busy2 = pending[bus.q_addr2];
  // Set follows clear so a same-address launch in the commit cycle stays pending.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      starve_cnt <= '0;
      pending <= '0;
    end else begin
      starve_cnt <= (!empty && pri_grant) ? starve_cnt + 1'b1 : '0;
      if (pop) pending[head.addr] <= 1'b0;
      if (bus.sb_set && bus.sb_addr != REG_ZERO) pending[bus.sb_addr] <= 1'b1;
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed test-plan steps then random traffic, checked against a
// queue-based reference model of the arbitration rules.
module tb_rf_wb_arbiter;
  import rf_pkg::*;
  localparam int DEPTH = 4;
  localparam int LIM = 3;
  logic clk = 0;
  logic reset = 1;
  rf_wb_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();
  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  rf_entry_t mq[$];
  bit [31:0] mp;
  int ms;
  logic e_we, e_stall, e_pop, e_pg, e_hc;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  rf_entry_t mh;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pri_valid = 0; bus.pri_addr = 0; bus.pri_data = 0;
    bus.sec_valid = 0; bus.sec_addr = 0; bus.sec_data = 0;
    bus.sb_set = 0; bus.sb_addr = 0; bus.q_addr1 = 0; bus.q_addr2 = 0;
  endtask

  // Grant table: empty -> primary; idle core -> head; aged head -> forced with stall.
  task automatic eval();
    e_stall = 0; e_pop = 0; e_pg = 0; mh = '0;
    if (mq.size() != 0) mh = mq[0];
    if (mq.size() == 0) e_pg = bus.pri_valid;
    else if (!bus.pri_valid) e_pop = 1;
    else if (ms < LIM) begin e_pg = 1; e_pop = (bus.pri_addr == mh.addr); end
    else begin e_pop = 1; e_stall = 1; end
    e_hc = e_pop && !e_pg;
    e_addr = e_hc ? mh.addr : bus.pri_addr;
    e_data = e_hc ? mh.data : bus.pri_data;
    e_we = (e_pg || e_hc) && e_addr != 0;
  endtask

  task automatic cyc();
    bit was_empty, push, sbs;
    logic [AW-1:0] sba;
    rf_entry_t pe;
    @(negedge clk);
    eval();
    chk("rf_we", bus.rf_we, e_we);
    if (e_we) begin
      chk("rf_addr", bus.rf_addr, e_addr);
      chk("rf_data", bus.rf_data, e_data);
    end
    chk("pri_stall", bus.pri_stall, e_stall);
    chk("sec_ready", bus.sec_ready, mq.size() < DEPTH);
    chk("fifo_count", bus.fifo_count, mq.size());
    chk("q_busy1", bus.q_busy1, mp[bus.q_addr1]);
    chk("q_busy2", bus.q_busy2, mp[bus.q_addr2]);
    was_empty = mq.size() == 0;
    push = bus.sec_valid && mq.size() < DEPTH;
    pe = '{addr: bus.sec_addr, data: bus.sec_data};
    sbs = bus.sb_set; sba = bus.sb_addr;
    @(posedge clk);
    if (e_pop) begin mp[mh.addr] = 0; void'(mq.pop_front()); end
    if (sbs && sba != 0) mp[sba] = 1;
    if (push) mq.push_back(pe);
    ms = (!was_empty && e_pg) ? ms + 1 : 0;
    #1;
  endtask

  initial begin
    idle();
    mq = {}; mp = 0; ms = 0;
    #3;
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_sec_ready", bus.sec_ready, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_stall", bus.pri_stall, 0);
    chk("rst_busy", bus.q_busy1, 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // Primary only
    bus.pri_valid = 1; bus.pri_addr = 8; bus.pri_data = 32'hDEADBEEF;
    #1;
    chk("pri_we", bus.rf_we, 1);
    chk("pri_addr", bus.rf_addr, 8);
    chk("pri_data", bus.rf_data, 32'hDEADBEEF);
    chk("pri_nostall", bus.pri_stall, 0);
    cyc();

    // Secondary drain with scoreboard
    idle(); bus.sb_set = 1; bus.sb_addr = 9; bus.q_addr1 = 9;
    cyc();
    idle(); bus.q_addr1 = 9; bus.sec_valid = 1; bus.sec_addr = 9; bus.sec_data = 32'h1234;
    #1 chk("sd_busy_pre", bus.q_busy1, 1);
    cyc();
    idle(); bus.q_addr1 = 9;
    #1;
    chk("sd_we", bus.rf_we, 1);
    chk("sd_addr", bus.rf_addr, 9);
    chk("sd_data", bus.rf_data, 32'h1234);
    chk("sd_busy_commit", bus.q_busy1, 1);
    cyc();
    #1 chk("sd_busy_after", bus.q_busy1, 0);

    // Starvation
    idle(); bus.sec_valid = 1; bus.sec_addr = 5; bus.sec_data = 32'h55; bus.sb_set = 1; bus.sb_addr = 5;
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); bus.pri_valid = 1; bus.pri_addr = AW'(10 + i); bus.pri_data = 32'(100 + i);
      #1;
      chk("st_pri_addr", bus.rf_addr, 10 + i);
      chk("st_pri_stall", bus.pri_stall, 0);
      cyc();
    end
    idle(); bus.pri_valid = 1; bus.pri_addr = 13; bus.pri_data = 32'h13;
    #1;
    chk("st_force_stall", bus.pri_stall, 1);
    chk("st_force_addr", bus.rf_addr, 5);
    chk("st_force_data", bus.rf_data, 32'h55);
    cyc();
    #1;
    chk("st_held_addr", bus.rf_addr, 13);
    chk("st_held_stall", bus.pri_stall, 0);
    cyc();

    // Full FIFO while the core keeps the port busy
    for (int i = 0; i < 4; i++) begin
      idle(); bus.pri_valid = 1; bus.pri_addr = 20; bus.pri_data = 32'(i);
      bus.sec_valid = 1; bus.sec_addr = AW'(1 + i); bus.sec_data = 32'(200 + i);
      cyc();
    end
    bus.sec_addr = 6; bus.sec_data = 32'h600;
    #1;
    chk("full_count", bus.fifo_count, 4);
    chk("full_ready", bus.sec_ready, 0);
    cyc();
    cyc();
    idle(); bus.sec_valid = 1; bus.sec_addr = 6; bus.sec_data = 32'h600;
    cyc();
    bus.sec_addr = 2; bus.sec_data = 32'h700;
    #1 chk("pushpop_before", bus.fifo_count, 3);
    cyc();
    #1 chk("pushpop_after", bus.fifo_count, 3);
    idle();
    for (int i = 0; i < 6; i++) cyc();

    // WAW kill
    idle(); bus.sec_valid = 1; bus.sec_addr = 7; bus.sec_data = 32'h77; bus.sb_set = 1; bus.sb_addr = 7;
    cyc();
    idle(); bus.pri_valid = 1; bus.pri_addr = 7; bus.pri_data = 32'hAA; bus.q_addr1 = 7;
    #1;
    chk("waw_data", bus.rf_data, 32'hAA);
    chk("waw_addr", bus.rf_addr, 7);
    cyc();
    idle(); bus.q_addr1 = 7;
    #1;
    chk("waw_pending", bus.q_busy1, 0);
    chk("waw_count", bus.fifo_count, 0);
    chk("waw_no_old", bus.rf_we, 0);
    cyc();

    // Secondary write to r0
    idle(); bus.sec_valid = 1; bus.sec_addr = 0; bus.sec_data = 32'h99;
    cyc();
    idle();
    #1 chk("r0_we", bus.rf_we, 0);
    cyc();
    #1 chk("r0_popped", bus.fifo_count, 0);

    // Async reset with buffered entries and pending bits
    for (int i = 0; i < 3; i++) begin
      idle(); bus.pri_valid = 1; bus.pri_addr = 30; bus.pri_data = 32'(i);
      bus.sec_valid = 1; bus.sec_addr = AW'(14 + i); bus.sec_data = 32'(i);
      bus.sb_set = 1; bus.sb_addr = AW'(14 + i);
      cyc();
    end
    idle(); bus.q_addr1 = 14; bus.q_addr2 = 16;
    #1 chk("ar_pre_count", bus.fifo_count, 3);
    #1 reset = 1;
    #1;
    chk("ar_count", bus.fifo_count, 0);
    chk("ar_busy1", bus.q_busy1, 0);
    chk("ar_busy2", bus.q_busy2, 0);
    chk("ar_ready_low", bus.sec_ready, 0);
    mq = {}; mp = 0; ms = 0;
    @(negedge clk); reset = 0;
    #1 chk("ar_ready_rel", bus.sec_ready, 1);
    @(posedge clk); #1;

    // Random traffic with the core honouring stalls
    idle();
    for (int n = 0; n < 500; n++) begin
      if (!e_stall) begin
        bus.pri_valid = $urandom_range(0, 99) < 55;
        bus.pri_addr = AW'($urandom_range(0, 7));
        bus.pri_data = $urandom;
      end
      bus.sec_valid = $urandom_range(0, 99) < 45;
      bus.sec_addr = AW'($urandom_range(0, 7));
      bus.sec_data = $urandom;
      bus.sb_set = $urandom_range(0, 99) < 30;
      bus.sb_addr = AW'($urandom_range(0, 7));
      bus.q_addr1 = AW'($urandom_range(0, 7));
      bus.q_addr2 = AW'($urandom_range(0, 31));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
